onehot_encoder_seq: RTL and testbench

- Sequential N-to-log2(N) encoder. It is the opposite direction of the team's 2-to-4 line decoder: it turns a line vector back into binary codes.
- Accepts a multi-hot line vector D through a valid/ready handshake and latches it.
- Emits the binary index A of every set line, one per output handshake, in priority order.
- Sits between decoded select/interrupt lines and logic that consumes binary codes.

---
 rtl/onehot_encoder_seq.sv | 107 ++++++++++
 tb/tb_onehot_encoder_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder_seq.sv
// rtl/onehot_encoder_seq.sv - sequential multi-hot to binary encoder, one code per output handshake.
// Define ONEHOT_ENC_MSB_FIRST_EN to emit the highest set line first instead of the lowest.
module onehot_encoder_seq #(
  parameter int N  = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  D,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] A,
  output logic          out_last,
  output logic          zero_err,
  output logic          busy
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  pend;
  logic [N-1:0]  pend_nxt;
  logic [N-1:0]  sel_mask;
  logic [AW-1:0] idx;
  logic          one_left;
  logic          in_xfer;
  logic          out_xfer;

  // Priority pick from the registered pend, so A stays put while the consumer stalls.
  always_comb begin
    idx = '0;
`ifdef ONEHOT_ENC_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
      if (pend[i]) idx = AW'(i);
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (pend[i]) idx = AW'(i);
    end
`endif
  end

  assign one_left = (pend != '0) && ((pend & (pend - N'(1))) == '0);
  assign sel_mask = N'(1) << idx;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pend     <= '0;
      zero_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend     <= pend_nxt;
      zero_err <= in_xfer && (D == '0);
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    case (state)
      IDLE: begin
        if (in_xfer && (D != '0)) begin
          pend_nxt  = D;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (out_xfer) begin
          pend_nxt = pend & ~sel_mask;
          if (one_left) begin
            pend_nxt  = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        pend_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    A         = '0;
    out_last  = 1'b0;
    case (state)
      IDLE: in_ready = !rst;
      EMIT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        A         = idx;
        out_last  = one_left;
      end
      default: in_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_onehot_encoder_seq.sv
// tb/tb_onehot_encoder_seq.sv - self-checking bench for onehot_encoder_seq (N=4).
// Honours ONEHOT_ENC_MSB_FIRST_EN to expect descending code order.
module tb_onehot_encoder_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] D;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] A;
  logic       out_last;
  logic       zero_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] a;
    logic       last;
  } beat_t;

  typedef struct {
    logic [3:0] d;
    int         n;
    logic [7:0] codes;
  } vec_t;

  beat_t exp_q[$];
  vec_t  tbl[6];

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_rst   = 1'b1;
  logic [1:0] prev_a     = '0;
  logic       prev_last  = 1'b0;

  onehot_encoder_seq #(.N(4), .AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A         (A),
    .out_last  (out_last),
    .zero_err  (zero_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference order: ascending line index, or descending with the MSB-first build.
  task automatic push_model(input logic [3:0] d);
    int total;
    int seen;
    beat_t b;
    total = 0;
    seen  = 0;
    for (int i = 0; i < 4; i++) if (d[i]) total++;
`ifdef ONEHOT_ENC_MSB_FIRST_EN
    for (int i = 3; i >= 0; i--) begin
`else
    for (int i = 0; i < 4; i++) begin
`endif
      if (d[i]) begin
        seen++;
        b.a    = 2'(i);
        b.last = (seen == total);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic send(input logic [3:0] d);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    D        = d;
    @(negedge clk);
    check("in_ready_at_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    D        = '0;
  endtask

  // Output side scoreboard plus hold-while-stalled checks.
  always @(negedge clk) begin
    beat_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual A=%0d required no beat at %0t", A, $time);
      end else begin
        e = exp_q.pop_front();
        check("beat_a", A, e.a);
        check("beat_last", out_last, e.last);
      end
    end
    if (prev_valid && !prev_ready && !prev_rst) begin
      check("hold_valid", out_valid, 1);
      check("hold_a", A, prev_a);
      check("hold_last", out_last, prev_last);
    end
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_rst   = rst;
    prev_a     = A;
    prev_last  = out_last;
  end

  initial begin
    beat_t b;
    logic [1:0] first_code;

`ifdef ONEHOT_ENC_MSB_FIRST_EN
    tbl[0] = '{d: 4'b1011, n: 3, codes: 8'b00_00_01_11};
    tbl[1] = '{d: 4'b0110, n: 2, codes: 8'b00_00_01_10};
    tbl[2] = '{d: 4'b1000, n: 1, codes: 8'b00_00_00_11};
    tbl[3] = '{d: 4'b1111, n: 4, codes: 8'b00_01_10_11};
    tbl[4] = '{d: 4'b0101, n: 2, codes: 8'b00_00_00_10};
    tbl[5] = '{d: 4'b0001, n: 1, codes: 8'b00_00_00_00};
`else
    tbl[0] = '{d: 4'b1011, n: 3, codes: 8'b00_11_01_00};
    tbl[1] = '{d: 4'b0110, n: 2, codes: 8'b00_00_10_01};
    tbl[2] = '{d: 4'b1000, n: 1, codes: 8'b00_00_00_11};
    tbl[3] = '{d: 4'b1111, n: 4, codes: 8'b11_10_01_00};
    tbl[4] = '{d: 4'b0101, n: 2, codes: 8'b00_00_10_00};
    tbl[5] = '{d: 4'b0001, n: 1, codes: 8'b00_00_00_00};
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    D         = '0;
    out_ready = 1'b1;

    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_a", A, 0);
    check("rst_out_last", out_last, 0);
    check("rst_zero_err", zero_err, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // Table vectors, out_ready held high: k back-to-back beats, then idle.
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        b.a    = tbl[i].codes[2*j +: 2];
        b.last = (j == tbl[i].n - 1);
        exp_q.push_back(b);
      end
      send(tbl[i].d);
      for (int j = 0; j < tbl[i].n; j++) begin
        @(negedge clk);
        check("tbl_out_valid", out_valid, 1);
        check("tbl_busy", busy, 1);
        check("tbl_in_ready_low", in_ready, 0);
      end
      @(negedge clk);
      check("tbl_idle_in_ready", in_ready, 1);
      check("tbl_idle_out_valid", out_valid, 0);
      check("tbl_idle_busy", busy, 0);
    end

    // Consumer stall for three cycles on D=0110.
`ifdef ONEHOT_ENC_MSB_FIRST_EN
    first_code = 2'd2;
`else
    first_code = 2'd1;
`endif
    out_ready = 1'b0;
    push_model(4'b0110);
    send(4'b0110);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_a", A, first_code);
      @(posedge clk);
      #1;
      if (i == 2) out_ready = 1'b1;
    end
    @(negedge clk);
    check("stall_fourth_a", A, first_code);
    @(negedge clk);
    check("stall_second_last", out_last, 1);
    @(negedge clk);
    check("stall_idle_in_ready", in_ready, 1);

    // All-zero vector: one-cycle error pulse, no beat.
    send(4'b0000);
    @(negedge clk);
    check("zero_err_pulse", zero_err, 1);
    check("zero_out_valid", out_valid, 0);
    check("zero_in_ready", in_ready, 1);
    check("zero_busy", busy, 0);
    @(negedge clk);
    check("zero_err_clear", zero_err, 0);

    // Reset after the first beat of D=1111 discards the rest.
    push_model(4'b1111);
    send(4'b1111);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready_back", in_ready, 1);
    push_model(4'b1000);
    send(4'b1000);
    @(negedge clk);
    check("single_msb_a", A, 3);
    check("single_msb_last", out_last, 1);
    @(negedge clk);
    check("single_msb_idle", out_valid, 0);

    // New input while emitting is ignored.
`ifdef ONEHOT_ENC_MSB_FIRST_EN
    first_code = 2'd1;
`else
    first_code = 2'd0;
`endif
    push_model(4'b0011);
    send(4'b0011);
    in_valid = 1'b1;
    D        = 4'b1100;
    @(negedge clk);
    check("ignore_in_ready", in_ready, 0);
    check("ignore_a", A, first_code);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    D        = '0;
    @(negedge clk);
    check("ignore_last", out_last, 1);
    @(negedge clk);
    check("ignore_idle_in_ready", in_ready, 1);
    check("ignore_idle_valid", out_valid, 0);

    // Reset and an input transfer in the same cycle: reset wins.
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    D        = 4'b0100;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    D        = '0;
    @(negedge clk);
    check("rst_xfer_out_valid", out_valid, 0);
    check("rst_xfer_busy", busy, 0);
    check("rst_xfer_in_ready", in_ready, 1);
    @(negedge clk);
    check("rst_xfer_still_idle", out_valid, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
